// File: rtl/rib_arb_pkg.sv
// Shared definitions for the RIB slave-port arbiter: state encoding, error data
// and the default master indices.
package rib_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [31:0] RIB_ERR_DATA = 32'hDEAD_BEEF;

  localparam int unsigned M_EX  = 0;
  localparam int unsigned M_DBG = 1;
  localparam int unsigned M_IF  = 2;

endpackage

// File: rtl/rib_arb_prio.sv
// Fixed-priority encoder (lowest index wins); starve_ovr promotes the top
// index (the fetch master) whenever it is requesting.
module rib_arb_prio
  import rib_arb_pkg::*;
#(
  parameter int unsigned NM = 3
) (
  input  logic [NM-1:0] req,
  input  logic          starve_ovr,
  output logic [2:0]    winner,
  output logic          any_req
);

  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (req[i] && !found) begin
        winner = i[2:0];
        found  = 1'b1;
      end
    end
    if (starve_ovr && req[NM-1]) begin
      winner = 3'(NM-1);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/rib_arb.sv
// RIB slave-port arbiter: NM masters share one slave; grant held until ack.
// Optional bus timeout enabled by defining RIB_ARB_TIMEOUT_EN.
module rib_arb
  import rib_arb_pkg::*;
#(
  parameter int unsigned NM           = 3,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_req_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*32-1:0] m_addr_i,
  input  logic [NM*32-1:0] m_wdata_i,
  output logic [NM-1:0]    m_ack_o,
  output logic [31:0]      m_rdata_o,
  output logic             s_req_o,
  output logic             s_we_o,
  output logic [31:0]      s_addr_o,
  output logic [31:0]      s_wdata_o,
  input  logic [31:0]      s_rdata_i,
  input  logic             s_ack_i,
  output logic [2:0]       grant_o,
  output logic             busy_o,
  output logic             rib_hold_flag_o,
  output logic             err_o
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  if (NM < 2 || NM > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("rib_arb: unsupported configuration");
  end

  arb_state_e    state;
  logic [2:0]    grant;
  logic [SW-1:0] starve_cnt;
  logic [2:0]    winner;
  logic          any_req;
  logic          busy;
  logic          to_hit;
  logic          done;

  rib_arb_prio #(.NM(NM)) u_prio (
    .req        (m_req_i),
    .starve_ovr (starve_cnt == SW'(STARVE_LIMIT)),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign busy = (state == BUSY);
  assign done = busy && (s_ack_i || to_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state <= BUSY;
            grant <= winner;
            if (winner == 3'(NM-1)) begin
              starve_cnt <= '0;
            end else if (m_req_i[NM-1] && starve_cnt != SW'(STARVE_LIMIT)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        BUSY: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RIB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic [TW-1:0] timeout_cnt;

  // Held at zero while idle, which gives the required clear on BUSY entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
    end else if (!busy) begin
      timeout_cnt <= '0;
    end else if (!s_ack_i) begin
      timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

  assign to_hit = busy && !s_ack_i && (timeout_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    m_ack_o   = '0;
    m_rdata_o = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      if (busy && grant == 3'(i)) begin
        s_we_o     = m_we_i[i];
        s_addr_o   = m_addr_i[32*i +: 32];
        s_wdata_o  = m_wdata_i[32*i +: 32];
        m_ack_o[i] = done;
      end
    end
    if (done) begin
      m_rdata_o = to_hit ? RIB_ERR_DATA : s_rdata_i;
    end
  end

  assign s_req_o         = busy;
  assign busy_o          = busy;
  assign grant_o         = grant;
  assign err_o           = to_hit;
  assign rib_hold_flag_o = |(m_req_i[NM-2:0] & ~m_ack_o[NM-2:0]);

endmodule

// File: tb/tb_rib_arb.sv
// Self-checking bench for rib_arb: directed scenarios plus a randomized run
// against a transaction-level arbitration model.
module tb_rib_arb;

  localparam int unsigned NM = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    m_req_i, m_we_i, m_ack_o;
  logic [NM*32-1:0] m_addr_i, m_wdata_i;
  logic [31:0]      m_rdata_o, s_addr_o, s_wdata_o, s_rdata_i;
  logic             s_req_o, s_we_o, s_ack_i, busy_o, rib_hold_flag_o, err_o;
  logic [2:0]       grant_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rib_arb #(.NM(NM), .STARVE_LIMIT(4), .TIMEOUT_CYC(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .m_req_i         (m_req_i),
    .m_we_i          (m_we_i),
    .m_addr_i        (m_addr_i),
    .m_wdata_i       (m_wdata_i),
    .m_ack_o         (m_ack_o),
    .m_rdata_o       (m_rdata_o),
    .s_req_o         (s_req_o),
    .s_we_o          (s_we_o),
    .s_addr_o        (s_addr_o),
    .s_wdata_o       (s_wdata_o),
    .s_rdata_i       (s_rdata_i),
    .s_ack_i         (s_ack_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .rib_hold_flag_o (rib_hold_flag_o),
    .err_o           (err_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req_i   = '0;
    m_we_i    = '0;
    m_addr_i  = '0;
    m_wdata_i = '0;
    s_ack_i   = 1'b0;
    s_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [106:0] outs;
    idle_inputs();
    rst = 1'b1;
    #2;
    outs = {m_ack_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_wdata_o,
            grant_o, busy_o, rib_hold_flag_o, err_o};
    n_chk++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    m_req_i = 3'b100;
    m_addr_i[95:64] = 32'h0000_1000;
    #1;
    n_chk++;
    if (s_req_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c0: s_req=%b busy=%b required 0 0", s_req_o, busy_o);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      s_ack_i   = (c == 3);
      s_rdata_i = (c == 3) ? 32'h1234_5678 : 32'h0;
      #1;
      n_chk++;
      if (s_req_o !== 1'b1 || busy_o !== 1'b1 || grant_o !== 3'd2 || s_addr_o !== 32'h1000) begin
        n_fail++;
        $display("FAIL single_busy c%0d: s_req=%b busy=%b grant=%0d addr=%h required 1 1 2 00001000",
                 c, s_req_o, busy_o, grant_o, s_addr_o);
      end
      n_chk++;
      if (m_ack_o !== ((c == 3) ? 3'b100 : 3'b000)) begin
        n_fail++;
        $display("FAIL single_ack c%0d: got %b", c, m_ack_o);
      end
    end
    n_chk++;
    if (m_rdata_o !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL single_rdata: got %h required 12345678", m_rdata_o);
    end
    tick();
    idle_inputs();
    #1;
    n_chk++;
    if (s_req_o !== 1'b0 || busy_o !== 1'b0 || m_ack_o !== 3'b000) begin
      n_fail++;
      $display("FAIL single_c4: s_req=%b busy=%b ack=%b required 0 0 000", s_req_o, busy_o, m_ack_o);
    end
  endtask

  task automatic test_contention();
    do_reset();
    m_req_i = 3'b101;
    #1;
    n_chk++;
    if (rib_hold_flag_o !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_hold_wait: got %b required 1", rib_hold_flag_o);
    end
    tick();
    s_ack_i = 1'b1;
    #1;
    n_chk++;
    if (grant_o !== 3'd0 || m_ack_o !== 3'b001 || rib_hold_flag_o !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_first: grant=%0d ack=%b hold=%b required 0 001 0", grant_o, m_ack_o, rib_hold_flag_o);
    end
    tick();
    s_ack_i = 1'b0;
    m_req_i = 3'b100;
    #1;
    n_chk++;
    if (busy_o !== 1'b0 || rib_hold_flag_o !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_gap: busy=%b hold=%b required 0 0", busy_o, rib_hold_flag_o);
    end
    tick();
    s_ack_i = 1'b1;
    #1;
    n_chk++;
    if (busy_o !== 1'b1 || grant_o !== 3'd2 || m_ack_o !== 3'b100) begin
      n_fail++;
      $display("FAIL cont_second: busy=%b grant=%0d ack=%b required 1 2 100", busy_o, grant_o, m_ack_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_starvation();
    logic [2:0] exp_g [11] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0};
    logic [2:0] exp_ack;
    do_reset();
    m_req_i = 3'b101;
    for (int r = 0; r < 11; r++) begin
      #1;
      n_chk++;
      if (busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL starve_gap r%0d: busy=%b required 0", r, busy_o);
      end
      tick();
      s_ack_i   = 1'b1;
      s_rdata_i = $urandom;
      exp_ack   = 3'b001 << exp_g[r];
      #1;
      n_chk++;
      if (grant_o !== exp_g[r] || m_ack_o !== exp_ack) begin
        n_fail++;
        $display("FAIL starve_grant r%0d: grant=%0d ack=%b required %0d %b", r, grant_o, m_ack_o, exp_g[r], exp_ack);
      end
      tick();
      s_ack_i = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_write();
    do_reset();
    m_req_i          = 3'b010;
    m_we_i           = 3'b010;
    m_addr_i[63:32]  = 32'h2000_0004;
    m_wdata_i[63:32] = 32'hA5A5_A5A5;
    #1;
    n_chk++;
    if (s_we_o !== 1'b0 || s_addr_o !== 32'h0 || s_wdata_o !== 32'h0) begin
      n_fail++;
      $display("FAIL write_idle: we=%b addr=%h wdata=%h required 0 0 0", s_we_o, s_addr_o, s_wdata_o);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      s_ack_i = (c == 3);
      #1;
      n_chk++;
      if (s_we_o !== 1'b1 || s_addr_o !== 32'h2000_0004 || s_wdata_o !== 32'hA5A5_A5A5) begin
        n_fail++;
        $display("FAIL write_bus c%0d: we=%b addr=%h wdata=%h", c, s_we_o, s_addr_o, s_wdata_o);
      end
      n_chk++;
      if (m_ack_o !== ((c == 3) ? 3'b010 : 3'b000) || rib_hold_flag_o !== (c != 3)) begin
        n_fail++;
        $display("FAIL write_ack c%0d: ack=%b hold=%b", c, m_ack_o, rib_hold_flag_o);
      end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_req_i = 3'b001;
    m_addr_i[31:0] = 32'h0000_0040;
    tick();
    tick();
    n_chk++;
    if (busy_o !== 1'b1 || s_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_busy: busy=%b s_req=%b required 1 1", busy_o, s_req_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_chk++;
    if (busy_o !== 1'b0 || s_req_o !== 1'b0 || m_ack_o !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_async: busy=%b s_req=%b ack=%b required 0 0 000", busy_o, s_req_o, m_ack_o);
    end
    tick();
    rst = 1'b0;
    #1;
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: busy=%b required 0", busy_o);
    end
    tick();
    s_ack_i = 1'b1;
    #1;
    n_chk++;
    if (busy_o !== 1'b1 || grant_o !== 3'd0 || m_ack_o !== 3'b001) begin
      n_fail++;
      $display("FAIL rstmid_rearb: busy=%b grant=%0d ack=%b required 1 0 001", busy_o, grant_o, m_ack_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
`ifdef RIB_ARB_TIMEOUT_EN
    logic [2:0]  exp_ack;
    logic        exp_err;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      m_req_i = 3'b100;
      #1;
      for (int c = 1; c <= 8; c++) begin
        tick();
        s_ack_i   = (pass == 1 && c == 8);
        s_rdata_i = 32'h0BAD_F00D;
        exp_ack   = (c == 8) ? 3'b100 : 3'b000;
        exp_err   = (pass == 0 && c == 8);
        #1;
        n_chk++;
        if (m_ack_o !== exp_ack || err_o !== exp_err || busy_o !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout p%0d c%0d: ack=%b err=%b busy=%b required %b %b 1",
                   pass, c, m_ack_o, err_o, busy_o, exp_ack, exp_err);
        end
      end
      n_chk++;
      if (m_rdata_o !== ((pass == 0) ? 32'hDEAD_BEEF : 32'h0BAD_F00D)) begin
        n_fail++;
        $display("FAIL timeout_rdata p%0d: got %h", pass, m_rdata_o);
      end
      tick();
      idle_inputs();
      #1;
      n_chk++;
      if (busy_o !== 1'b0 || err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_after p%0d: busy=%b err=%b required 0 0", pass, busy_o, err_o);
      end
    end
`else
    int bad;
    do_reset();
    m_req_i = 3'b100;
    bad = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (busy_o !== 1'b1 || m_ack_o !== 3'b000 || err_o !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL no_timeout: %0d bad cycles required 0", bad);
    end
    s_ack_i = 1'b1;
    #1;
    n_chk++;
    if (m_ack_o !== 3'b100 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_ack: ack=%b err=%b required 100 0", m_ack_o, err_o);
    end
    tick();
    idle_inputs();
    #1;
    n_chk++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL no_timeout_idle: busy=%b required 0", busy_o);
    end
`endif
  endtask

  task automatic test_random();
    logic [2:0]  req, cur, exp_ack, we;
    logic [31:0] addr [3];
    logic [31:0] wdat [3];
    logic [31:0] rd;
    logic        exp_hold;
    int          starve, win, lat;
    bit          drop;
    do_reset();
    starve = 0;
    req    = '0;
    for (int r = 0; r < 60; r++) begin
      req |= 3'($urandom_range(0, 7));
      if (req == 3'b000) req = 3'b100;
      for (int k = 0; k < 3; k++) begin
        addr[k] = $urandom;
        wdat[k] = $urandom;
        we[k]   = 1'($urandom_range(0, 1));
      end
      m_req_i   = req;
      m_we_i    = we;
      m_addr_i  = {addr[2], addr[1], addr[0]};
      m_wdata_i = {wdat[2], wdat[1], wdat[0]};
      #1;
      n_chk++;
      if (busy_o !== 1'b0 || s_req_o !== 1'b0 || m_ack_o !== 3'b000 || s_addr_o !== 32'h0 ||
          rib_hold_flag_o !== (|req[1:0])) begin
        n_fail++;
        $display("FAIL rand_idle r%0d: busy=%b s_req=%b ack=%b addr=%h hold=%b", r, busy_o, s_req_o,
                 m_ack_o, s_addr_o, rib_hold_flag_o);
      end
      // Reference arbitration: fetch promoted after 4 lost rounds, else lowest index.
      if (starve == 4 && req[2]) win = 2;
      else if (req[0]) win = 0;
      else if (req[1]) win = 1;
      else win = 2;
      if (win == 2) starve = 0;
      else if (req[2]) starve = (starve < 4) ? starve + 1 : 4;
      lat  = $urandom_range(1, 4);
      drop = ($urandom_range(0, 3) == 0);
      cur  = drop ? (req & ~(3'b001 << win)) : req;
      for (int c = 1; c <= lat; c++) begin
        tick();
        m_req_i   = cur;
        s_ack_i   = (c == lat);
        rd        = $urandom;
        s_rdata_i = rd;
        exp_ack   = (c == lat) ? (3'b001 << win) : 3'b000;
        exp_hold  = |(cur[1:0] & ~exp_ack[1:0]);
        #1;
        n_chk++;
        if (s_req_o !== 1'b1 || grant_o !== 3'(win) || s_we_o !== we[win] ||
            s_addr_o !== addr[win] || s_wdata_o !== wdat[win]) begin
          n_fail++;
          $display("FAIL rand_bus r%0d c%0d: s_req=%b grant=%0d we=%b addr=%h wdata=%h required 1 %0d %b %h %h",
                   r, c, s_req_o, grant_o, s_we_o, s_addr_o, s_wdata_o, win, we[win], addr[win], wdat[win]);
        end
        n_chk++;
        if (m_ack_o !== exp_ack || rib_hold_flag_o !== exp_hold ||
            (c == lat && m_rdata_o !== rd)) begin
          n_fail++;
          $display("FAIL rand_ack r%0d c%0d: ack=%b hold=%b rdata=%h required %b %b %h",
                   r, c, m_ack_o, rib_hold_flag_o, m_rdata_o, exp_ack, exp_hold, rd);
        end
      end
      tick();
      s_ack_i  = 1'b0;
      req[win] = 1'b0;
      m_req_i  = req;
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_starvation();
    test_write();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
